// File: rtl/hdc_pkg.sv
// Shared HDC encoder constants, binder shift table and the bind-scheduler state type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hdc_pkg;

    localparam int HV_DIM          = 1024;
    localparam int FEATURES_PER_CC = 8;
    localparam int NUM_FEATURES    = 512;

    // Chunk counter width; never zero, so a single-chunk sample still gets a 1-bit index.
    function automatic int chunk_w_of(input int n_chunks);
        return (n_chunks > 1) ? $clog2(n_chunks) : 1;
    endfunction

    localparam int NUM_CHUNKS = NUM_FEATURES / FEATURES_PER_CC;
    localparam int CHUNK_W    = chunk_w_of(NUM_CHUNKS);

    // Per-lane rotate amount inside one binder pack; feature f of chunk k is
    // rotated by k*FEATURES_PER_CC + SHIFTS[f].
    localparam int SHIFTS [FEATURES_PER_CC] = '{0, 1, 2, 3, 4, 5, 6, 7};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } enc_sched_state_t;

endpackage

// File: rtl/enc_sched_pipe.sv
// Two-stage (read, bind-register) valid/chunk/last tag pipeline for the bind scheduler.
// Latency: exactly 2 cycles from i_rd_en to o_vld while downstream accepts.
// Backpressure: both stages freeze while o_vld & !i_acc_ready; o_adv tells the issuer when it may read.
// Ports: clk/rst (sync, active-high); i_rd_en/i_chunk/i_last issue side; i_acc_ready from accumulator;
//        o_adv advance strobe; o_vld/o_chunk/o_last bind-beat tag.
module enc_sched_pipe #(
    parameter int CHUNK_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_rd_en,
    input  logic [CHUNK_W-1:0] i_chunk,
    input  logic               i_last,
    input  logic               i_acc_ready,
    output logic               o_adv,
    output logic               o_vld,
    output logic [CHUNK_W-1:0] o_chunk,
    output logic               o_last
);

    logic               r_s1_vld;
    logic [CHUNK_W-1:0] r_s1_chunk;
    logic               r_s1_last;
    logic               r_s2_vld;
    logic [CHUNK_W-1:0] r_s2_chunk;
    logic               r_s2_last;
    logic               w_adv;

    // Whole pipe moves as one; an empty output slot or an accepted beat lets it shift.
    assign w_adv = !r_s2_vld || i_acc_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_chunk <= '0;
            r_s1_last  <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_chunk <= '0;
            r_s2_last  <= 1'b0;
        end else if (w_adv) begin
            r_s2_vld   <= r_s1_vld;
            r_s2_chunk <= r_s1_chunk;
            r_s2_last  <= r_s1_last;
            r_s1_vld   <= i_rd_en;
            r_s1_chunk <= i_chunk;
            r_s1_last  <= i_last && i_rd_en;
        end
    end

    assign o_adv   = w_adv;
    assign o_vld   = r_s2_vld;
    assign o_chunk = r_s2_chunk;
    assign o_last  = r_s2_last;

endmodule

// File: rtl/enc_bind_sched.sv
// Sequences level-HV reads chunk by chunk and tags binder-pack outputs for the accumulator.
// Latency: start -> first read 1 cycle; read -> bind_valid 2 cycles; last accept -> done 1 cycle.
// Backpressure: acc_ready low holds the bind beat and stops reads; nothing dropped or repeated.
// Ports: clk, rst (sync, active-high); start in; busy, done out; lvl_rd_en/chunk_idx to level memory;
//        bind_valid/bind_chunk/bind_last with acc_ready handshake to the accumulator.
// Option: define ENC_SCHED_PERF_EN to add the 32-bit saturating stall_cnt output.
module enc_bind_sched #(
    parameter  int HV_DIM          = hdc_pkg::HV_DIM,
    parameter  int FEATURES_PER_CC = hdc_pkg::FEATURES_PER_CC,
    parameter  int NUM_FEATURES    = hdc_pkg::NUM_FEATURES,
    localparam int NUM_CHUNKS      = NUM_FEATURES / FEATURES_PER_CC,
    localparam int CHUNK_W         = hdc_pkg::chunk_w_of(NUM_CHUNKS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               lvl_rd_en,
    output logic [CHUNK_W-1:0] chunk_idx,
    output logic               bind_valid,
    output logic [CHUNK_W-1:0] bind_chunk,
    output logic               bind_last,
    input  logic               acc_ready,
    output logic               done
`ifdef ENC_SCHED_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    import hdc_pkg::*;

    // Elaboration-time guard on the sample geometry.
    if ((NUM_FEATURES % FEATURES_PER_CC) != 0 || NUM_CHUNKS < 1 || HV_DIM < FEATURES_PER_CC) begin : g_cfg_err
        $error("enc_bind_sched: NUM_FEATURES must be a nonzero multiple of FEATURES_PER_CC <= HV_DIM");
    end

    enc_sched_state_t   r_state;
    logic [CHUNK_W-1:0] r_chunk_idx;
    logic               r_busy;
    logic               r_done;
    logic               w_adv;
    logic               w_rd_en;
    logic               w_last_issue;
    logic               w_last_acc;

    assign w_last_issue = (r_chunk_idx == CHUNK_W'(NUM_CHUNKS - 1));
    assign w_last_acc   = bind_valid && bind_last && acc_ready;
    // Read strobe must see this cycle's acc_ready, so it is decoded rather than registered.
    assign w_rd_en      = (r_state == RUN) && w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_chunk_idx <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= RUN;
                        r_chunk_idx <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_rd_en) begin
                        // Index parks on the final chunk instead of wrapping.
                        if (w_last_issue) begin
                            r_state <= DRAIN;
                        end else begin
                            r_chunk_idx <= r_chunk_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_acc) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    enc_sched_pipe #(
        .CHUNK_W(CHUNK_W)
    ) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_rd_en    (w_rd_en),
        .i_chunk    (r_chunk_idx),
        .i_last     (w_last_issue),
        .i_acc_ready(acc_ready),
        .o_adv      (w_adv),
        .o_vld      (bind_valid),
        .o_chunk    (bind_chunk),
        .o_last     (bind_last)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign lvl_rd_en = w_rd_en;
    assign chunk_idx = r_chunk_idx;

`ifdef ENC_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_stall_cnt <= '0;
        end else if (bind_valid && !acc_ready && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_enc_bind_sched.sv
// Directed bench for enc_bind_sched: 8-chunk instance (A) and 1-chunk instance (B).
// Latency: n/a (testbench).
// Backpressure: acc_ready driven per cycle from stimulus tables.
module tb_enc_bind_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst       = 1'b1;
    logic acc_ready = 1'b1;
    logic start_a   = 1'b0;
    logic start_b   = 1'b0;

    logic       a_busy, a_rd, a_bv, a_bl, a_done;
    logic [2:0] a_ci, a_bc;
    logic       b_busy, b_rd, b_bv, b_bl, b_done;
    logic [0:0] b_ci, b_bc;
`ifdef ENC_SCHED_PERF_EN
    logic [31:0] a_stall, b_stall;
`endif

    enc_bind_sched #(.HV_DIM(1024), .FEATURES_PER_CC(8), .NUM_FEATURES(64)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .lvl_rd_en(a_rd),
        .chunk_idx(a_ci), .bind_valid(a_bv), .bind_chunk(a_bc), .bind_last(a_bl),
        .acc_ready(acc_ready), .done(a_done)
`ifdef ENC_SCHED_PERF_EN
        , .stall_cnt(a_stall)
`endif
    );

    enc_bind_sched #(.HV_DIM(1024), .FEATURES_PER_CC(8), .NUM_FEATURES(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .lvl_rd_en(b_rd),
        .chunk_idx(b_ci), .bind_valid(b_bv), .bind_chunk(b_bc), .bind_last(b_bl),
        .acc_ready(acc_ready), .done(b_done)
`ifdef ENC_SCHED_PERF_EN
        , .stall_cnt(b_stall)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Per-cycle stimulus tables and sampled outputs.
    logic        st_v  [64];
    logic        rdy_v [64];
    logic        rst_v [64];
    logic [31:0] s_rd [64], s_ci [64], s_bv [64], s_bc [64], s_bl [64], s_done [64], s_busy [64];

    // Beats accepted during the last scan.
    int acc_chunk [$];
    int acc_last  [$];
    int done_cnt;
    int done_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_stim();
        for (int c = 0; c < 64; c++) begin
            st_v[c]  = 1'b0;
            rdy_v[c] = 1'b1;
            rst_v[c] = 1'b0;
        end
    endtask

    // Inputs change 1ns after the rising edge, outputs are sampled on the falling edge.
    task automatic run(input int sel, input int n);
        for (int c = 0; c < n; c++) begin
            rst       = rst_v[c];
            acc_ready = rdy_v[c];
            start_a   = (sel == 0) ? st_v[c] : 1'b0;
            start_b   = (sel == 1) ? st_v[c] : 1'b0;
            @(negedge clk);
            if (sel == 0) begin
                s_rd[c] = 32'(a_rd);  s_ci[c] = 32'(a_ci);  s_bv[c] = 32'(a_bv);
                s_bc[c] = 32'(a_bc);  s_bl[c] = 32'(a_bl);  s_done[c] = 32'(a_done);
                s_busy[c] = 32'(a_busy);
            end else begin
                s_rd[c] = 32'(b_rd);  s_ci[c] = 32'(b_ci);  s_bv[c] = 32'(b_bv);
                s_bc[c] = 32'(b_bc);  s_bl[c] = 32'(b_bl);  s_done[c] = 32'(b_done);
                s_busy[c] = 32'(b_busy);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0; acc_ready = 1'b1; start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic scan(input int n);
        acc_chunk.delete();
        acc_last.delete();
        done_cnt = 0;
        done_cyc = -1;
        for (int c = 0; c < n; c++) begin
            if (s_bv[c] == 1 && rdy_v[c] && !rst_v[c]) begin
                acc_chunk.push_back(int'(s_bc[c]));
                acc_last.push_back(int'(s_bl[c]));
            end
            if (s_done[c] == 1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
    endtask

    task automatic check_reset_state(input string tag, input int c);
        check_eq({tag, "_busy"}, s_busy[c], 0);
        check_eq({tag, "_done"}, s_done[c], 0);
        check_eq({tag, "_rd"},   s_rd[c],   0);
        check_eq({tag, "_bv"},   s_bv[c],   0);
        check_eq({tag, "_bl"},   s_bl[c],   0);
        check_eq({tag, "_ci"},   s_ci[c],   0);
        check_eq({tag, "_bc"},   s_bc[c],   0);
    endtask

    task automatic check_in_order(input string tag, input int n_exp);
        check_eq({tag, "_beats"}, acc_chunk.size(), n_exp);
        for (int i = 0; i < acc_chunk.size() && i < n_exp; i++) begin
            check_eq($sformatf("%s_chunk[%0d]", tag, i), acc_chunk[i], i);
            check_eq($sformatf("%s_last[%0d]", tag, i), acc_last[i], (i == n_exp - 1) ? 1 : 0);
        end
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    // 8 chunks, acc_ready high, start at cycle 0.
    task automatic nominal_a(input string tag);
        clr_stim();
        st_v[0] = 1'b1;
        run(0, 15);
        for (int c = 0; c < 15; c++) begin
            check_eq($sformatf("%s_rd[%0d]", tag, c), s_rd[c], (c >= 1 && c <= 8) ? 1 : 0);
            if (c >= 1 && c <= 8)
                check_eq($sformatf("%s_ci[%0d]", tag, c), s_ci[c], c - 1);
            check_eq($sformatf("%s_bv[%0d]", tag, c), s_bv[c], (c >= 3 && c <= 10) ? 1 : 0);
            if (c >= 3 && c <= 10)
                check_eq($sformatf("%s_bc[%0d]", tag, c), s_bc[c], c - 3);
            check_eq($sformatf("%s_bl[%0d]", tag, c), s_bl[c], (c == 10) ? 1 : 0);
            check_eq($sformatf("%s_done[%0d]", tag, c), s_done[c], (c == 11) ? 1 : 0);
            check_eq($sformatf("%s_busy[%0d]", tag, c), s_busy[c], (c >= 1 && c <= 10) ? 1 : 0);
        end
        scan(15);
        check_in_order(tag, 8);
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset values, both instances.
        clr_stim();
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        run(0, 3);
        check_reset_state("rstA1", 1);
        check_reset_state("rstA2", 2);
        run(1, 3);
        check_reset_state("rstB2", 2);

        // Nominal streaming.
        nominal_a("nom");

        // Backpressure while chunk 2 is presented.
        clr_stim();
        st_v[0] = 1'b1;
        rdy_v[5] = 1'b0; rdy_v[6] = 1'b0; rdy_v[7] = 1'b0;
        run(0, 18);
        for (int c = 5; c <= 8; c++) begin
            check_eq($sformatf("bp_bv[%0d]", c), s_bv[c], 1);
            check_eq($sformatf("bp_bc[%0d]", c), s_bc[c], 2);
        end
        for (int c = 5; c <= 7; c++)
            check_eq($sformatf("bp_rd[%0d]", c), s_rd[c], 0);
        check_eq("bp_rd8", s_rd[8], 1);
        check_eq("bp_ci8", s_ci[8], 4);
        scan(18);
        check_in_order("bp", 8);
        check_eq("bp_done_cyc", done_cyc, 14);
`ifdef ENC_SCHED_PERF_EN
        check_eq("bp_stall_cnt", a_stall, 3);
`endif

        // Extra starts mid-run and on the done cycle are ignored.
        clr_stim();
        st_v[0] = 1'b1; st_v[4] = 1'b1; st_v[11] = 1'b1;
        run(0, 16);
        scan(16);
        check_in_order("restart", 8);
        check_eq("restart_done_cyc", done_cyc, 11);
        for (int c = 12; c < 16; c++) begin
            check_eq($sformatf("restart_busy[%0d]", c), s_busy[c], 0);
            check_eq($sformatf("restart_rd[%0d]", c), s_rd[c], 0);
        end

        // Reset mid-run while chunk 5 is being read.
        clr_stim();
        st_v[0] = 1'b1;
        rst_v[6] = 1'b1;
        run(0, 15);
        check_eq("mrst_ci6", s_ci[6], 5);
        check_eq("mrst_rd6", s_rd[6], 1);
        check_reset_state("mrst7", 7);
        for (int c = 8; c < 15; c++) begin
            check_eq($sformatf("mrst_bv[%0d]", c), s_bv[c], 0);
            check_eq($sformatf("mrst_done[%0d]", c), s_done[c], 0);
        end
        nominal_a("post_rst");

        // Single-chunk instance.
        clr_stim();
        st_v[0] = 1'b1;
        run(1, 8);
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("one_rd[%0d]", c), s_rd[c], (c == 1) ? 1 : 0);
            check_eq($sformatf("one_bv[%0d]", c), s_bv[c], (c == 3) ? 1 : 0);
            check_eq($sformatf("one_bl[%0d]", c), s_bl[c], (c == 3) ? 1 : 0);
            check_eq($sformatf("one_done[%0d]", c), s_done[c], (c == 4) ? 1 : 0);
            check_eq($sformatf("one_busy[%0d]", c), s_busy[c], (c >= 1 && c <= 3) ? 1 : 0);
        end
        check_eq("one_ci1", s_ci[1], 0);
        check_eq("one_bc3", s_bc[3], 0);

        // Single chunk held by two stall cycles.
        clr_stim();
        st_v[0] = 1'b1;
        rdy_v[3] = 1'b0; rdy_v[4] = 1'b0;
        run(1, 9);
        for (int c = 0; c < 9; c++) begin
            check_eq($sformatf("one_bp_bv[%0d]", c), s_bv[c], (c >= 3 && c <= 5) ? 1 : 0);
            check_eq($sformatf("one_bp_bl[%0d]", c), s_bl[c], (c >= 3 && c <= 5) ? 1 : 0);
            check_eq($sformatf("one_bp_done[%0d]", c), s_done[c], (c == 6) ? 1 : 0);
            check_eq($sformatf("one_bp_rd[%0d]", c), s_rd[c], (c == 1) ? 1 : 0);
        end
`ifdef ENC_SCHED_PERF_EN
        check_eq("one_bp_stall_cnt", b_stall, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
